// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states and the
// "no register" source/destination marker.
package pipe_hazard_ctrl_pkg;

    // $zero can never create a true dependency, so it doubles as "unused".
    localparam logic [4:0] RNONE = 5'd0;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_MDWAIT = 2'd1,
        ST_HALT   = 2'd2
    } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_hz_sat_cnt.sv
// Saturating event counter used for the stall and flush performance counters.
module hz_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the 5-stage core: load-use, mispredict, exception and
// mul/div sequencing, producing stall/bubble strobes plus perf counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       d_srcA,
    input  logic [4:0]       d_srcB,
    input  logic [4:0]       E_dstM,
    input  logic             E_isload,
    input  logic             E_ismd,
    input  logic             e_bmiss,
    input  logic             m_exc,
    input  logic             W_halt,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_stall,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             md_go,
    output logic             md_abort,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hz_state_e  state_q, state_d;
    logic [3:0] md_cnt_q, md_cnt_d;
    // Set for the single RUN cycle after a mul/div completes, so the same
    // instruction still sitting in E is not issued a second time.
    logic       md_done_q, md_done_d;

    logic f_stall_c, d_stall_c, d_bubble_c, e_stall_c, e_bubble_c;
    logic m_bubble_c, w_stall_c, md_go_c, md_abort_c, flush_inc;
    logic load_use, exc;

    assign load_use = E_isload && (E_dstM != RNONE) &&
                      ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign exc      = m_exc || W_halt;

    always_comb begin
        state_d    = state_q;
        md_cnt_d   = md_cnt_q;
        md_done_d  = 1'b0;
        f_stall_c  = 1'b0;
        d_stall_c  = 1'b0;
        d_bubble_c = 1'b0;
        e_stall_c  = 1'b0;
        e_bubble_c = 1'b0;
        m_bubble_c = 1'b0;
        w_stall_c  = 1'b0;
        md_go_c    = 1'b0;
        md_abort_c = 1'b0;
        flush_inc  = 1'b0;

        if (state_q == ST_HALT) begin
            f_stall_c  = 1'b1;
            d_stall_c  = 1'b1;
            e_stall_c  = 1'b1;
            m_bubble_c = 1'b1;
            w_stall_c  = 1'b1;
        end else if (exc) begin
            f_stall_c  = 1'b1;
            d_stall_c  = 1'b1;
            m_bubble_c = 1'b1;
            w_stall_c  = 1'b1;
            md_abort_c = (state_q == ST_MDWAIT);
            md_cnt_d   = 4'd0;
            state_d    = ST_HALT;
        end else if (state_q == ST_MDWAIT) begin
            f_stall_c  = 1'b1;
            d_stall_c  = 1'b1;
            e_stall_c  = 1'b1;
            m_bubble_c = 1'b1;
            if (md_cnt_q == 4'd1) begin
                state_d   = ST_RUN;
                md_cnt_d  = 4'd0;
                md_done_d = 1'b1;
            end else begin
                md_cnt_d = md_cnt_q - 4'd1;
            end
        end else if (e_bmiss) begin
            d_bubble_c = 1'b1;
            e_bubble_c = 1'b1;
            flush_inc  = 1'b1;
        end else if (load_use) begin
            f_stall_c  = 1'b1;
            d_stall_c  = 1'b1;
            e_bubble_c = 1'b1;
        end else if (E_ismd && !md_done_q) begin
            md_go_c    = 1'b1;
            f_stall_c  = 1'b1;
            d_stall_c  = 1'b1;
            e_stall_c  = 1'b1;
            m_bubble_c = 1'b1;
            md_cnt_d   = 4'(MD_LAT - 1);
            state_d    = ST_MDWAIT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RUN;
            md_cnt_q  <= 4'd0;
            md_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            md_cnt_q  <= md_cnt_d;
            md_done_q <= md_done_d;
        end
    end

    // Outputs are forced low for the whole reset window, not just after the edge.
    assign F_stall  = f_stall_c  & ~rst;
    assign D_stall  = d_stall_c  & ~rst;
    assign D_bubble = d_bubble_c & ~rst;
    assign E_stall  = e_stall_c  & ~rst;
    assign E_bubble = e_bubble_c & ~rst;
    assign M_bubble = m_bubble_c & ~rst;
    assign W_stall  = w_stall_c  & ~rst;
    assign md_go    = md_go_c    & ~rst;
    assign md_abort = md_abort_c & ~rst;
    assign busy     = (state_q == ST_MDWAIT) & ~rst;
    assign halted   = (state_q == ST_HALT) & ~rst;

    hz_sat_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (F_stall),
        .cnt (stall_cnt)
    );

    hz_sat_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_inc & ~rst),
        .cnt (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: each scenario task drives vectors and
// compares strobes/counters against hand-computed values.
module tb_pipe_hazard_ctrl;
    import pipe_hazard_ctrl_pkg::*;

    localparam int MD_LAT = 4;
    localparam int CNT_W  = 4;

    // Strobe vector order: F_stall D_stall D_bubble E_stall E_bubble M_bubble
    // W_stall md_go md_abort busy halted
    localparam logic [10:0] S_NONE  = 11'b000_0000_0000;
    localparam logic [10:0] S_FST   = 11'b100_0000_0000;
    localparam logic [10:0] S_DST   = 11'b010_0000_0000;
    localparam logic [10:0] S_DBUB  = 11'b001_0000_0000;
    localparam logic [10:0] S_EST   = 11'b000_1000_0000;
    localparam logic [10:0] S_EBUB  = 11'b000_0100_0000;
    localparam logic [10:0] S_MBUB  = 11'b000_0010_0000;
    localparam logic [10:0] S_WST   = 11'b000_0001_0000;
    localparam logic [10:0] S_GO    = 11'b000_0000_1000;
    localparam logic [10:0] S_ABORT = 11'b000_0000_0100;
    localparam logic [10:0] S_BUSY  = 11'b000_0000_0010;
    localparam logic [10:0] S_HALTD = 11'b000_0000_0001;

    localparam logic [10:0] EXP_LU    = S_FST | S_DST | S_EBUB;
    localparam logic [10:0] EXP_BMISS = S_DBUB | S_EBUB;
    localparam logic [10:0] EXP_MDGO  = S_FST | S_DST | S_EST | S_MBUB | S_GO;
    localparam logic [10:0] EXP_MDW   = S_FST | S_DST | S_EST | S_MBUB | S_BUSY;
    localparam logic [10:0] EXP_EXCMD = S_FST | S_DST | S_MBUB | S_WST | S_ABORT | S_BUSY;
    localparam logic [10:0] EXP_HALT  = S_FST | S_DST | S_EST | S_MBUB | S_WST | S_HALTD;

    logic             clk;
    logic             rst;
    logic [4:0]       d_srcA, d_srcB, E_dstM;
    logic             E_isload, E_ismd, e_bmiss, m_exc, W_halt;
    logic             F_stall, D_stall, D_bubble, E_stall, E_bubble;
    logic             M_bubble, W_stall, md_go, md_abort, busy, halted;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [10:0]      obs;

    int checks;
    int errors;

    pipe_hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .d_srcA    (d_srcA),
        .d_srcB    (d_srcB),
        .E_dstM    (E_dstM),
        .E_isload  (E_isload),
        .E_ismd    (E_ismd),
        .e_bmiss   (e_bmiss),
        .m_exc     (m_exc),
        .W_halt    (W_halt),
        .F_stall   (F_stall),
        .D_stall   (D_stall),
        .D_bubble  (D_bubble),
        .E_stall   (E_stall),
        .E_bubble  (E_bubble),
        .M_bubble  (M_bubble),
        .W_stall   (W_stall),
        .md_go     (md_go),
        .md_abort  (md_abort),
        .busy      (busy),
        .halted    (halted),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    assign obs = {F_stall, D_stall, D_bubble, E_stall, E_bubble, M_bubble,
                  W_stall, md_go, md_abort, busy, halted};

    // Clock / reset: rising edges at 5, 15, 25, ...; inputs change on falling edges.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        d_srcA   = 5'd1;
        d_srcB   = 5'd2;
        E_dstM   = 5'd3;
        E_isload = 1'b0;
        E_ismd   = 1'b0;
        e_bmiss  = 1'b0;
        m_exc    = 1'b0;
        W_halt   = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        E_ismd = 1'b1;
        m_exc  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (obs !== S_NONE) begin
            errors++;
            $display("FAIL reset_strobes: got %b want %b", obs, S_NONE);
        end
        checks++;
        if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        end
        clear_inputs();
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== S_NONE) begin
            errors++;
            $display("FAIL reset_idle_run: got %b want %b", obs, S_NONE);
        end
    endtask

    task automatic test_load_use();
        pulse_reset();
        E_isload = 1'b1;
        E_dstM   = 5'd8;
        d_srcA   = 5'd3;
        d_srcB   = 5'd8;
        #1;
        checks++;
        if (obs !== EXP_LU) begin
            errors++;
            $display("FAIL load_use_strobes: got %b want %b", obs, EXP_LU);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (obs !== S_NONE) begin
            errors++;
            $display("FAIL load_use_release: got %b want %b", obs, S_NONE);
        end
        checks++;
        if (stall_cnt !== 4'd1) begin
            errors++;
            $display("FAIL load_use_stall_cnt: got %0d want 1", stall_cnt);
        end
        // Both sides RNONE must not look like a dependency.
        E_isload = 1'b1;
        E_dstM   = RNONE;
        d_srcA   = RNONE;
        d_srcB   = 5'd4;
        #1;
        checks++;
        if (obs !== S_NONE) begin
            errors++;
            $display("FAIL load_use_rnone: got %b want %b", obs, S_NONE);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (stall_cnt !== 4'd1) begin
            errors++;
            $display("FAIL load_use_rnone_cnt: got %0d want 1", stall_cnt);
        end
    endtask

    task automatic test_mispredict();
        pulse_reset();
        E_isload = 1'b1;
        E_dstM   = 5'd9;
        d_srcA   = 5'd9;
        e_bmiss  = 1'b1;
        #1;
        checks++;
        if (obs !== EXP_BMISS) begin
            errors++;
            $display("FAIL bmiss_strobes: got %b want %b", obs, EXP_BMISS);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (flush_cnt !== 4'd1) begin
            errors++;
            $display("FAIL bmiss_flush_cnt: got %0d want 1", flush_cnt);
        end
        checks++;
        if (stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL bmiss_stall_cnt: got %0d want 0", stall_cnt);
        end
    endtask

    task automatic test_muldiv();
        pulse_reset();
        E_ismd = 1'b1;
        #1;
        checks++;
        if (obs !== EXP_MDGO) begin
            errors++;
            $display("FAIL md_entry: got %b want %b", obs, EXP_MDGO);
        end
        for (int i = 0; i < MD_LAT - 1; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (obs !== EXP_MDW) begin
                errors++;
                $display("FAIL md_wait_%0d: got %b want %b", i, obs, EXP_MDW);
            end
        end
        // Same mul/div still in E on the release cycle: must not reissue.
        @(negedge clk);
        #1;
        checks++;
        if (obs !== S_NONE) begin
            errors++;
            $display("FAIL md_release: got %b want %b", obs, S_NONE);
        end
        checks++;
        if (stall_cnt !== 4'd4) begin
            errors++;
            $display("FAIL md_stall_cnt: got %0d want 4", stall_cnt);
        end
        @(negedge clk);
        #1;
        checks++;
        if (obs !== EXP_MDGO) begin
            errors++;
            $display("FAIL md_second_issue: got %b want %b", obs, EXP_MDGO);
        end
    endtask

    task automatic test_exception();
        pulse_reset();
        E_ismd = 1'b1;
        @(negedge clk);
        @(negedge clk);
        m_exc = 1'b1;
        #1;
        checks++;
        if (obs !== EXP_EXCMD) begin
            errors++;
            $display("FAIL exc_in_mdwait: got %b want %b", obs, EXP_EXCMD);
        end
        @(negedge clk);
        m_exc = 1'b0;
        for (int i = 0; i < 11; i++) begin
            #1;
            checks++;
            if (obs !== EXP_HALT) begin
                errors++;
                $display("FAIL halt_hold_%0d: got %b want %b", i, obs, EXP_HALT);
            end
            @(negedge clk);
        end
        checks++;
        if (flush_cnt !== 4'd0) begin
            errors++;
            $display("FAIL halt_flush_cnt: got %0d want 0", flush_cnt);
        end
    endtask

    task automatic test_saturate_and_async_reset();
        pulse_reset();
        E_isload = 1'b1;
        E_dstM   = 5'd12;
        d_srcA   = 5'd12;
        for (int i = 0; i < 10; i++) @(negedge clk);
        #1;
        checks++;
        if (stall_cnt !== 4'd10) begin
            errors++;
            $display("FAIL sat_mid: got %0d want 10", stall_cnt);
        end
        for (int i = 0; i < 10; i++) @(negedge clk);
        #1;
        checks++;
        if (stall_cnt !== 4'd15) begin
            errors++;
            $display("FAIL sat_hold: got %0d want 15", stall_cnt);
        end
        clear_inputs();
        E_ismd = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (obs !== EXP_MDW) begin
            errors++;
            $display("FAIL pre_reset_busy: got %b want %b", obs, EXP_MDW);
        end
        // Assert reset between edges: outputs and counters must clear at once.
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== S_NONE) begin
            errors++;
            $display("FAIL async_rst_strobes: got %b want %b", obs, S_NONE);
        end
        checks++;
        if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
            errors++;
            $display("FAIL async_rst_counters: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        end
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== S_NONE) begin
            errors++;
            $display("FAIL post_rst_run: got %b want %b", obs, S_NONE);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_mispredict();
        test_muldiv();
        test_exception();
        test_saturate_and_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
